// File: rtl/vending_pkg.sv
// Encodings and FSM state type shared between the vending FSM and the dispenser controller.
package vending_pkg;

  typedef enum logic [1:0] {
    PROD_NONE = 2'b00,
    PROD_A    = 2'b01,
    PROD_B    = 2'b10,
    PROD_C    = 2'b11
  } prod_t;

  typedef enum logic [2:0] {
    IDLE,
    MOTOR,
    EJECT,
    GAP,
    DONE,
    FAULT
  } state_t;

  localparam int NUM_MOTORS = 3;

  function automatic logic [NUM_MOTORS-1:0] prod_onehot(input logic [1:0] p);
    logic [NUM_MOTORS-1:0] oh;
    oh = '0;
    case (p)
      PROD_A:  oh = 3'b001;
      PROD_B:  oh = 3'b010;
      PROD_C:  oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dispensador_ctrl_temporizador.sv
// Loadable down-counter that stops at zero; tc_o flags the last cycle of a timed phase.
module temporizador #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/dispensador_ctrl.sv
// Dispenser actuator controller: runs the product motor until drop is sensed, then pulses
// the coin ejector once per change coin. Outputs are registered from the next state.
module dispensador_ctrl
  import vending_pkg::*;
#(
  parameter int MOTOR_TIMEOUT = 16,
  parameter int EJECT_CYCLES  = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] producto,
  input  logic       listo,
  input  logic [1:0] cambio,
  input  logic       sensor_caida,
  input  logic       borrar_falla,
  output logic [2:0] motor,
  output logic       expulsar,
  output logic       ocupado,
  output logic       entregado,
  output logic       falla
);

  // Phases are timed by loading N-1 on entry and leaving on terminal count.
  localparam logic [CNT_W-1:0] MOTOR_LD = CNT_W'(MOTOR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EJECT_LD = CNT_W'(EJECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic       listo_q;
  logic [1:0] prod_q, prod_d;
  logic [1:0] cambio_q, cambio_d;
  logic [2:0] motor_q, motor_d;
  logic       expulsar_q, expulsar_d;
  logic       ocupado_q, ocupado_d;
  logic       entregado_q, entregado_d;
  logic       falla_q, falla_d;

  logic             start;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_tc;

  assign start = listo & ~listo_q;

  temporizador #(.CNT_W(CNT_W)) u_tmr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    cambio_d = cambio_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          prod_d   = producto;
          cambio_d = cambio;
          tmr_load = 1'b1;
          if (producto != PROD_NONE) begin
            state_d = MOTOR;
            tmr_val = MOTOR_LD;
          end else if (cambio != 2'd0) begin
            state_d = EJECT;
            tmr_val = EJECT_LD;
          end
        end
      end
      MOTOR: begin
        // Delivery wins over timeout when both land in the final cycle.
        if (sensor_caida) begin
          if (cambio_q != 2'd0) begin
            state_d  = EJECT;
            tmr_load = 1'b1;
            tmr_val  = EJECT_LD;
          end else begin
            state_d = DONE;
          end
        end else if (tmr_tc) begin
          state_d = FAULT;
        end
      end
      EJECT: begin
        if (tmr_tc) begin
          cambio_d = cambio_q - 2'd1;
          if (cambio_d != 2'd0) begin
            state_d  = GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (tmr_tc) begin
          state_d  = EJECT;
          tmr_load = 1'b1;
          tmr_val  = EJECT_LD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        cambio_d = 2'd0;
        if (borrar_falla) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    motor_d     = (state_d == MOTOR) ? prod_onehot(prod_d) : 3'b000;
    expulsar_d  = (state_d == EJECT);
    ocupado_d   = (state_d != IDLE);
    entregado_d = (state_d == DONE);
    falla_d     = (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      listo_q     <= 1'b0;
      prod_q      <= 2'd0;
      cambio_q    <= 2'd0;
      motor_q     <= 3'b000;
      expulsar_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      entregado_q <= 1'b0;
      falla_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      listo_q     <= listo;
      prod_q      <= prod_d;
      cambio_q    <= cambio_d;
      motor_q     <= motor_d;
      expulsar_q  <= expulsar_d;
      ocupado_q   <= ocupado_d;
      entregado_q <= entregado_d;
      falla_q     <= falla_d;
    end
  end

  assign motor     = motor_q;
  assign expulsar  = expulsar_q;
  assign ocupado   = ocupado_q;
  assign entregado = entregado_q;
  assign falla     = falla_q;

endmodule

// File: tb/tb_dispensador_ctrl.sv
// Bench for dispensador_ctrl: table-driven vectors, directed corner sequences and random
// stimulus checked against a per-transaction output-schedule model.
module tb_dispensador_ctrl;

  localparam int TMO = 16;
  localparam int EJ  = 4;
  localparam int GP  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] producto;
  logic       listo;
  logic [1:0] cambio;
  logic       sensor_caida;
  logic       borrar_falla;
  logic [2:0] motor;
  logic       expulsar, ocupado, entregado, falla;

  dispensador_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .producto     (producto),
    .listo        (listo),
    .cambio       (cambio),
    .sensor_caida (sensor_caida),
    .borrar_falla (borrar_falla),
    .motor        (motor),
    .expulsar     (expulsar),
    .ocupado      (ocupado),
    .entregado    (entregado),
    .falla        (falla)
  );

  always #5 clk = ~clk;

  // {motor[2:0], expulsar, ocupado, entregado, falla}
  wire [6:0] dut_v = {motor, expulsar, ocupado, entregado, falla};

  localparam bit [6:0] V_IDLE  = 7'b000_0000;
  localparam bit [6:0] V_FAULT = 7'b000_0101;
  localparam bit [6:0] V_EJ    = 7'b000_1100;
  localparam bit [6:0] V_GAP   = 7'b000_0100;
  localparam bit [6:0] V_DONE  = 7'b000_0110;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: expected outputs for upcoming cycles, computed when a transaction starts.
  bit [6:0] sched[$];
  bit       fault_mode;
  bit       listo_prev;
  bit       cur_fault;
  int       plan_d;
  int       sensor_at;
  int       cyc = 0;

  function automatic void expect1(string nm, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endfunction

  function automatic void model_reset();
    sched.delete();
    fault_mode = 1'b0;
    listo_prev = 1'b0;
    sensor_at  = -1;
  endfunction

  function automatic bit [6:0] next_expected();
    cur_fault = 1'b0;
    if (sched.size() > 0) return sched.pop_front();
    if (fault_mode) begin
      cur_fault = 1'b1;
      return V_FAULT;
    end
    return V_IDLE;
  endfunction

  // d = cycles after start at which the drop sensor fires; d > TMO means it never does.
  function automatic void build(bit [1:0] p, bit [1:0] c, int d);
    bit [2:0] m;
    int n;
    if (p != 2'd0) begin
      m = 3'b001 << (p - 1);
      n = (d >= 1 && d <= TMO) ? d : TMO;
      for (int i = 0; i < n; i++) sched.push_back({m, 4'b0100});
      if (d < 1 || d > TMO) begin
        fault_mode = 1'b1;
        return;
      end
    end
    for (int k = 0; k < c; k++) begin
      for (int i = 0; i < EJ; i++) sched.push_back(V_EJ);
      if (k < c - 1) for (int i = 0; i < GP; i++) sched.push_back(V_GAP);
    end
    if (p != 2'd0 || c != 2'd0) sched.push_back(V_DONE);
  endfunction

  task automatic step(input bit l, input bit [1:0] p, input bit [1:0] c,
                      input bit s, input bit b, input bit rnd);
    bit [6:0] e;
    bit       sv;
    @(posedge clk);
    #1;
    cyc++;
    e = next_expected();
    n_tests++;
    if (dut_v !== e) begin
      n_fail++;
      $display("FAIL model cyc=%0d actual=%b required=%b", cyc, dut_v, e);
    end
    sv = s;
    if (rnd) sv = (cyc == sensor_at) || (e[6:4] == 3'b000 && ($urandom % 3 == 0));
    listo = l; producto = p; cambio = c; sensor_caida = sv; borrar_falla = b;
    if (cur_fault && b) fault_mode = 1'b0;
    if (!e[2] && l && !listo_prev && !cur_fault) begin
      build(p, c, plan_d);
      sensor_at = (plan_d >= 1 && plan_d <= TMO) ? cyc + plan_d : -1;
    end
    listo_prev = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit       l;
    bit [1:0] p;
    bit [1:0] c;
    bit       s;
    bit [6:0] exp;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cnt_a, cnt_b, cnt_c;
    bit lr;

    // Product B, two coins, sensor three cycles after start
    tbl[0]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_IDLE};
    tbl[1]  = '{1'b1, 2'd2, 2'd2, 1'b0, 7'b010_0100};
    tbl[2]  = '{1'b1, 2'd2, 2'd2, 1'b0, 7'b010_0100};
    tbl[3]  = '{1'b1, 2'd2, 2'd2, 1'b1, 7'b010_0100};
    tbl[4]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[5]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[6]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[7]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[8]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_GAP};
    tbl[9]  = '{1'b1, 2'd2, 2'd2, 1'b0, V_GAP};
    tbl[10] = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[11] = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[12] = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[13] = '{1'b1, 2'd2, 2'd2, 1'b0, V_EJ};
    tbl[14] = '{1'b1, 2'd2, 2'd2, 1'b0, V_DONE};
    tbl[15] = '{1'b1, 2'd2, 2'd2, 1'b0, V_IDLE};

    rst = 1'b1; listo = 1'b0; producto = 2'd0; cambio = 2'd0;
    sensor_caida = 1'b0; borrar_falla = 1'b0;
    model_reset();
    plan_d = 99;
    #12;
    expect1("reset_state", dut_v, 0);
    rst = 1'b0;

    idle(2);
    plan_d = 3;
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].l, tbl[i].p, tbl[i].c, tbl[i].s, 1'b0, 1'b0);
      n_tests++;
      if (dut_v !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL table[%0d] actual=%b required=%b", i, dut_v, tbl[i].exp);
      end
    end

    // Product A, no sensor: timeout, fault ignores new starts, cleared by operator
    idle(1);
    plan_d = 99;
    cnt_a = 0;
    step(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TMO; i++) begin
      step(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
      if (motor == 3'b001) cnt_a++;
    end
    expect1("motor_on_cycles", cnt_a, TMO);
    step(1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    expect1("fault_set", falla, 1);
    expect1("fault_motor_off", motor, 0);
    step(1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    expect1("fault_ignores_start", falla, 1);
    step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect1("fault_cleared", falla, 0);
    expect1("fault_cleared_idle", ocupado, 0);

    // Refund of three coins: no motor, three pulses, one completion
    idle(1);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    step(1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      if (motor != 3'b000) cnt_a++;
      if (expulsar) cnt_b++;
      if (entregado) cnt_c++;
    end
    expect1("refund_no_motor", cnt_a, 0);
    expect1("refund_eject_cycles", cnt_b, 3 * EJ);
    expect1("refund_done", cnt_c, 1);

    // listo held high for 40 cycles: exactly one transaction
    plan_d = 2;
    cnt_c = 0;
    step(1'b1, 2'd3, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b1, 2'd3, 2'd1, (i == 2), 1'b0, 1'b0);
      if (entregado) cnt_c++;
    end
    expect1("held_listo_one_done", cnt_c, 1);

    // Reset asserted during the second eject pulse
    idle(1);
    plan_d = 1;
    step(1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    expect1("second_pulse_active", expulsar, 1);
    #2 rst = 1'b1;
    #1 expect1("async_reset_outputs", dut_v, 0);
    model_reset();
    #1 rst = 1'b0;
    plan_d = 2;
    cnt_c = 0;
    idle(1);
    step(1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      if (entregado) cnt_c++;
    end
    expect1("post_reset_done", cnt_c, 1);

    // Sensor in the final timeout cycle counts as delivery
    plan_d = TMO;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    step(1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= TMO + 8; i++) begin
      step(1'b0, 2'd1, 2'd1, (i == TMO), 1'b0, 1'b0);
      if (falla) cnt_a++;
      if (expulsar) cnt_b++;
      if (entregado) cnt_c++;
    end
    expect1("last_cycle_no_fault", cnt_a, 0);
    expect1("last_cycle_eject", cnt_b, EJ);
    expect1("last_cycle_done", cnt_c, 1);

    // Random traffic against the schedule model
    lr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 3 == 0) lr = ~lr;
      plan_d = 1 + int'($urandom % 20);
      step(lr, 2'($urandom % 4), 2'($urandom % 4), 1'b0, ($urandom % 8 == 0), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
